add_renorm_pipe: RTL and testbench
==================================

Name: add_renorm_pipe

Overview:
- Parametrised, pipelined normalise-and-round stage for the floating-point adder datapath. Sits between the significand adder and the result register.
- Takes the raw sum significand (with carry and G/R/S bits), sign and pre-normalisation exponent.
- Performs right-renormalisation on carry and left-normalisation via leading-zero count.
- Rounds in one of four runtime-selectable modes, renormalises after rounding, and flags zero/overflow/underflow/inexact.
- Valid/ready handshake on both sides; latency 3 cycles.

Parameters:
- MANT_W, 8, output significand width including hidden bit
- EXP_W, 8, exponent width; exp 0 reserved for zero, all-ones reserved for overflow/infinity
- GRS, 3, extra low bits below LSB (minimum 2); top extra bit = guard, the rest are ORed into sticky
- TAG_W, 4, sideband tag carried unchanged alongside the data

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  input token valid
- in_ready  out  1  stage accepts input this cycle
- in_sign  in  1  result sign
- in_mant  in  MANT_W+GRS+1  raw sum; MSB = carry, next bit = hidden-bit position, then MANT_W-1 fraction bits, then GRS bits
- in_exp  in  EXP_W  exponent before normalisation
- in_rmode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_sign  out  1  result sign
- out_mant  out  MANT_W  normalised, rounded significand (hidden bit included)
- out_exp  out  EXP_W  result exponent
- out_tag  out  TAG_W  sideband
- out_zero, out_ovf, out_uf, out_inexact  out  1 each  status flags

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All stage valids and out_valid = 0.
  - All data/flag outputs = 0.
  - In-flight tokens are discarded.
  - in_ready = 0 while rst_n=0, and 1 on the first cycle after reset release.
- Flow control:
  - Single global advance: adv = !out_valid | out_ready; in_ready = adv.
  - On adv, every stage moves forward one step; bubbles propagate as valid=0.
  - On !adv, all stages hold and their contents stay stable.
  - A transfer happens on the edge where valid & ready.
  - Latency: an accepted token appears at out_valid exactly 3 cycles later if no stall occurs.
  - Throughput: 1 token/cycle.
  - Order is preserved; no token is lost or duplicated.
- Stage 1 (normalise). Let SW = MANT_W+GRS+1.
  - in_mant == 0: zero token; out_mant = 0, out_exp = 0, out_zero = 1, no other flags, no rounding.
  - Carry bit set: shift right 1; the shifted-out bit is ORed into sticky; exp + 1.
  - Otherwise: lzc = leading zeros counted from bit SW-2. Shift left by lzc, zero-filled; exp - lzc.
  - If exp <= lzc: flush to zero; out_mant = 0, out_exp = 0, out_zero = 1, out_uf = 1, out_inexact = 1. No denormals.
  - Exponent arithmetic uses EXP_W+1 bits internally.
- Stage 2 (round):
  - lsb = mant[GRS]; g = guard; s = OR of the remaining extra bits.
  - Increment rule by mode:
    - RNE: inc = g & (s | lsb).
    - RTZ: inc = 0.
    - +inf: inc = !sign & (g|s).
    - -inf: inc = sign & (g|s).
  - inexact = g | s.
  - Mantissa result is MANT_W+1 bits wide.
- Stage 3 (post-round and output register):
  - If rounding carried to 2^MANT_W: mant = 1000..0 and exp + 1.
  - If the final exp >= 2^EXP_W-1, including the carry case: out_exp = all-ones, out_mant = 1000..0, out_ovf = 1, out_inexact = 1.
  - Flags are mutually exclusive except inexact.
- Simultaneous events: carry right-shift, rounding carry and overflow can all occur in one token; handle them in the stage order above.
- The rounding mode is sampled with the token (per-token, not global).

Test Plan (defaults MANT_W=8, EXP_W=8, GRS=3; RNE unless noted):
- Carry renorm: in_mant=0xC00, exp=0x80 -> out_mant=0xC0, out_exp=0x81, all flags 0, out_valid exactly 3 cycles after acceptance.
- Tie-to-even: in_mant=0x40C, exp=0x80 -> out_mant=0x82, inexact=1. Same token with RTZ -> 0x81, inexact=1.
- Round carry: in_mant=0x7FC, exp=0x80 -> out_mant=0x80, out_exp=0x81. With rmode=11 and sign=0 -> out_mant=0xFF, out_exp=0x80, inexact=1.
- Left normalise and underflow:
  - in_mant=0x010, exp=0x80 -> out_mant=0x80, out_exp=0x7A.
  - Same with exp=0x06 -> out_zero=1, out_uf=1, out_inexact=1, out_exp=0.
- Zero and overflow:
  - in_mant=0x000 -> out_zero=1 only.
  - in_mant=0xC00, exp=0xFE -> out_exp=0xFF, out_mant=0x80, out_ovf=1.
- Backpressure and reset: stream 6 tokens with tags 0..5 and hold out_ready=0 for 4 cycles mid-stream.
  - Required: in_ready=0 while out_valid & !out_ready; tags exit in order 0..5 with no loss or duplication.
  - Assert rst_n=0 mid-stream -> out_valid=0 next cycle; no stale token after release.

Source files
------------

// File: rtl/add_renorm_pipe_if.sv
// Handshake and data bundle for the add_renorm_pipe normalise/round stage.
// Input side: in_valid/in_ready plus sign, raw sum significand (carry, hidden,
// fraction, extra bits), pre-normalisation exponent, rounding mode and tag.
// Output side: out_valid/out_ready plus sign, rounded significand, exponent,
// tag and the zero/overflow/underflow/inexact flags.
// modport slave is the pipe itself; modport master is whoever drives it.
interface add_renorm_pipe_if #(
    parameter int MANT_W = 8,
    parameter int EXP_W  = 8,
    parameter int GRS    = 3,
    parameter int TAG_W  = 4
);
    localparam int SW = MANT_W + GRS + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [SW-1:0]     in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic [1:0]        in_rmode;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;
    logic              out_ovf;
    logic              out_uf;
    logic              out_inexact;

    modport master (
        output in_valid, in_sign, in_mant, in_exp, in_rmode, in_tag,
        input  in_ready,
        input  out_valid, out_sign, out_mant, out_exp, out_tag,
        input  out_zero, out_ovf, out_uf, out_inexact,
        output out_ready
    );

    modport slave (
        input  in_valid, in_sign, in_mant, in_exp, in_rmode, in_tag,
        output in_ready,
        output out_valid, out_sign, out_mant, out_exp, out_tag,
        output out_zero, out_ovf, out_uf, out_inexact,
        input  out_ready
    );
endinterface

// File: rtl/add_renorm_pipe.sv
// Three-stage normalise-and-round pipe for the floating-point adder.
//   stage 1: carry right-shift / leading-zero left-normalise, zero and flush
//   stage 2: rounding increment (RNE, RTZ, +inf, -inf per token)
//   stage 3: post-round renormalise, overflow saturation, output register
// Ports: clk, rst_n (synchronous, active-low), bus (add_renorm_pipe_if.slave)
// carrying both handshakes. One global advance moves every stage together.
module add_renorm_pipe #(
    parameter int MANT_W = 8,
    parameter int EXP_W  = 8,
    parameter int GRS    = 3,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    add_renorm_pipe_if.slave  bus
);
    localparam int SW  = MANT_W + GRS + 1;
    localparam int NW  = SW - 1;           // hidden + fraction + extra bits
    localparam int EW1 = EXP_W + 1;        // one spare bit for carry/borrow
    localparam int LZW = $clog2(SW);
    localparam logic [EW1-1:0]    EXP_SAT  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [MANT_W-1:0] MANT_ONE = {1'b1, {(MANT_W-1){1'b0}}};

    logic adv;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [NW-1:0]     s1_mant_q,  s1_mant_d;
    logic [EW1-1:0]    s1_exp_q,   s1_exp_d;
    logic              s1_zero_q,  s1_zero_d;
    logic              s1_uf_q,    s1_uf_d;
    logic [1:0]        s1_rmode_q, s1_rmode_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_sign_q,  s2_sign_d;
    logic [MANT_W:0]   s2_rnd_q,   s2_rnd_d;
    logic [EW1-1:0]    s2_exp_q,   s2_exp_d;
    logic              s2_zero_q,  s2_zero_d;
    logic              s2_uf_q,    s2_uf_d;
    logic              s2_inx_q,   s2_inx_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;

    logic              out_valid_q, out_valid_d;
    logic              out_sign_q,  out_sign_d;
    logic [MANT_W-1:0] out_mant_q,  out_mant_d;
    logic [EXP_W-1:0]  out_exp_q,   out_exp_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
    logic              out_zero_q,  out_zero_d;
    logic              out_ovf_q,   out_ovf_d;
    logic              out_uf_q,    out_uf_d;
    logic              out_inx_q,   out_inx_d;

    logic [LZW-1:0]    lzc;
    logic              lz_found;
    logic [EW1-1:0]    in_exp_x;
    logic [MANT_W-1:0] s2_frac;
    logic              rnd_lsb, rnd_g, rnd_s, rnd_inc;
    logic [MANT_W-1:0] post_mant;
    logic [EW1-1:0]    post_exp;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = rst_n && adv;
    assign in_exp_x     = {1'b0, bus.in_exp};

    // Leading zeros counted from the hidden-bit position downwards.
    always_comb begin
        lzc      = '0;
        lz_found = 1'b0;
        for (int i = SW - 2; i >= 0; i--) begin
            if (!lz_found) begin
                if (bus.in_mant[i]) lz_found = 1'b1;
                else                lzc      = lzc + LZW'(1);
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mant_d  = s1_mant_q;
        s1_exp_d   = s1_exp_q;
        s1_zero_d  = s1_zero_q;
        s1_uf_d    = s1_uf_q;
        s1_rmode_d = s1_rmode_q;
        s1_tag_d   = s1_tag_q;
        if (adv) begin
            s1_valid_d = bus.in_valid;
            s1_sign_d  = bus.in_sign;
            s1_rmode_d = bus.in_rmode;
            s1_tag_d   = bus.in_tag;
            s1_zero_d  = 1'b0;
            s1_uf_d    = 1'b0;
            if (bus.in_mant == '0) begin
                s1_mant_d = '0;
                s1_exp_d  = '0;
                s1_zero_d = 1'b1;
            end else if (bus.in_mant[SW-1]) begin
                // Bit shifted out on the carry renorm folds into sticky.
                s1_mant_d    = bus.in_mant[SW-1:1];
                s1_mant_d[0] = bus.in_mant[1] | bus.in_mant[0];
                s1_exp_d     = in_exp_x + EW1'(1);
            end else if (in_exp_x <= EW1'(lzc)) begin
                // No denormals: anything that would need exp <= 0 flushes.
                s1_mant_d = '0;
                s1_exp_d  = '0;
                s1_zero_d = 1'b1;
                s1_uf_d   = 1'b1;
            end else begin
                s1_mant_d = bus.in_mant[NW-1:0] << lzc;
                s1_exp_d  = in_exp_x - EW1'(lzc);
            end
        end
    end

    assign s2_frac = s1_mant_q[NW-1:GRS];
    assign rnd_lsb = s1_mant_q[GRS];
    assign rnd_g   = s1_mant_q[GRS-1];
    assign rnd_s   = |s1_mant_q[GRS-2:0];

    always_comb begin
        case (s1_rmode_q)
            2'b00:   rnd_inc = rnd_g & (rnd_s | rnd_lsb);
            2'b01:   rnd_inc = 1'b0;
            2'b10:   rnd_inc = !s1_sign_q & (rnd_g | rnd_s);
            default: rnd_inc = s1_sign_q & (rnd_g | rnd_s);
        endcase
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_rnd_d   = s2_rnd_q;
        s2_exp_d   = s2_exp_q;
        s2_zero_d  = s2_zero_q;
        s2_uf_d    = s2_uf_q;
        s2_inx_d   = s2_inx_q;
        s2_tag_d   = s2_tag_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_exp_d   = s1_exp_q;
            s2_zero_d  = s1_zero_q;
            s2_uf_d    = s1_uf_q;
            s2_tag_d   = s1_tag_q;
            if (s1_zero_q) begin
                s2_rnd_d = '0;
                s2_inx_d = s1_uf_q;
            end else begin
                s2_rnd_d = {1'b0, s2_frac} + {{MANT_W{1'b0}}, rnd_inc};
                s2_inx_d = rnd_g | rnd_s;
            end
        end
    end

    // Rounding can carry out to 2^MANT_W; the result is then exactly 1.0 x 2.
    always_comb begin
        if (s2_rnd_q[MANT_W]) begin
            post_mant = MANT_ONE;
            post_exp  = s2_exp_q + EW1'(1);
        end else begin
            post_mant = s2_rnd_q[MANT_W-1:0];
            post_exp  = s2_exp_q;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_tag_d   = out_tag_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        out_uf_d    = out_uf_q;
        out_inx_d   = out_inx_q;
        if (adv) begin
            out_valid_d = s2_valid_q;
            out_sign_d  = s2_sign_q;
            out_tag_d   = s2_tag_q;
            out_zero_d  = s2_zero_q;
            out_uf_d    = s2_uf_q;
            out_ovf_d   = 1'b0;
            out_inx_d   = s2_inx_q;
            out_mant_d  = post_mant;
            out_exp_d   = post_exp[EXP_W-1:0];
            if (!s2_zero_q && post_exp >= EXP_SAT) begin
                out_ovf_d  = 1'b1;
                out_inx_d  = 1'b1;
                out_exp_d  = '1;
                out_mant_d = MANT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mant_q   <= '0;
            s1_exp_q    <= '0;
            s1_zero_q   <= 1'b0;
            s1_uf_q     <= 1'b0;
            s1_rmode_q  <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_rnd_q    <= '0;
            s2_exp_q    <= '0;
            s2_zero_q   <= 1'b0;
            s2_uf_q     <= 1'b0;
            s2_inx_q    <= 1'b0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_tag_q   <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_uf_q    <= 1'b0;
            out_inx_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mant_q   <= s1_mant_d;
            s1_exp_q    <= s1_exp_d;
            s1_zero_q   <= s1_zero_d;
            s1_uf_q     <= s1_uf_d;
            s1_rmode_q  <= s1_rmode_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_rnd_q    <= s2_rnd_d;
            s2_exp_q    <= s2_exp_d;
            s2_zero_q   <= s2_zero_d;
            s2_uf_q     <= s2_uf_d;
            s2_inx_q    <= s2_inx_d;
            s2_tag_q    <= s2_tag_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_tag_q   <= out_tag_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
            out_uf_q    <= out_uf_d;
            out_inx_q   <= out_inx_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_sign    = out_sign_q;
    assign bus.out_mant    = out_mant_q;
    assign bus.out_exp     = out_exp_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_zero    = out_zero_q;
    assign bus.out_ovf     = out_ovf_q;
    assign bus.out_uf      = out_uf_q;
    assign bus.out_inexact = out_inx_q;
endmodule

// File: tb/tb_add_renorm_pipe.sv
// Self-checking bench for add_renorm_pipe: directed vector table, backpressure
// and mid-stream reset sequences, and a randomized stream scored against an
// arithmetic reference model.
module tb_add_renorm_pipe;
    localparam int MANT_W = 8;
    localparam int EXP_W  = 8;
    localparam int GRS    = 3;
    localparam int TAG_W  = 4;
    localparam int SW     = MANT_W + GRS + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_renorm_pipe_if #(.MANT_W(MANT_W), .EXP_W(EXP_W), .GRS(GRS), .TAG_W(TAG_W)) bus ();

    add_renorm_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W), .GRS(GRS), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic              sign;
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              zero, ovf, uf, inx;
        logic [TAG_W-1:0]  tag;
    } res_t;

    typedef struct {
        logic              sign;
        logic [SW-1:0]     m;
        logic [EXP_W-1:0]  e;
        logic [1:0]        rm;
        logic [MANT_W-1:0] xm;
        logic [EXP_W-1:0]  xe;
        logic [3:0]        xf;   // {zero, ovf, uf, inexact}
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    res_t sbq[$];
    logic [TAG_W-1:0] tags_out[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: locate the leading one, treat everything below the target
    // LSB as an exact remainder, and round by comparing it with one half ulp.
    function automatic res_t model(input logic sign, input logic [SW-1:0] m,
                                   input logic [EXP_W-1:0] e, input logic [1:0] rm,
                                   input logic [TAG_W-1:0] tag);
        res_t r;
        longint mv, q, rem, half, ms;
        int p, sh, ex;
        logic inc;
        r.sign = sign; r.tag = tag; r.mant = '0; r.exp = '0;
        r.zero = 1'b0; r.ovf = 1'b0; r.uf = 1'b0; r.inx = 1'b0;
        mv = longint'(m);
        if (mv == 0) begin
            r.zero = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < SW; i++) if (mv[i]) p = i;
        sh = p - (SW - 2);
        if (sh <= 0 && int'(e) <= -sh) begin
            r.zero = 1'b1; r.uf = 1'b1; r.inx = 1'b1;
            return r;
        end
        ex = int'(e) + sh;
        if (sh >= 0) begin
            q    = mv >> (GRS + sh);
            rem  = mv - (q << (GRS + sh));
            half = longint'(1) << (GRS + sh - 1);
        end else begin
            ms   = mv << (-sh);
            q    = ms >> GRS;
            rem  = ms - (q << GRS);
            half = longint'(1) << (GRS - 1);
        end
        case (rm)
            2'd0:    inc = (rem > half) || (rem == half && q[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = !sign && rem != 0;
            default: inc = sign && rem != 0;
        endcase
        q = q + (inc ? 1 : 0);
        if (q == (longint'(1) << MANT_W)) begin
            q  = q >> 1;
            ex = ex + 1;
        end
        r.inx = (rem != 0);
        if (ex >= (1 << EXP_W) - 1) begin
            r.ovf = 1'b1; r.inx = 1'b1; r.exp = '1;
            r.mant[MANT_W-1] = 1'b1;
        end else begin
            r.mant = q[MANT_W-1:0];
            r.exp  = ex[EXP_W-1:0];
        end
        return r;
    endfunction

    // Scoreboard: predict on every accept, compare on every output transfer.
    always @(negedge clk) begin
        res_t e;
        #2;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            chk("in_ready_vs_adv", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_result",
                        longint'({bus.out_sign, bus.out_mant, bus.out_exp, bus.out_zero,
                                  bus.out_ovf, bus.out_uf, bus.out_inexact, bus.out_tag}),
                        longint'({e.sign, e.mant, e.exp, e.zero, e.ovf, e.uf, e.inx, e.tag}));
                end
                tags_out.push_back(bus.out_tag);
            end
            if (bus.in_valid && bus.in_ready)
                sbq.push_back(model(bus.in_sign, bus.in_mant, bus.in_exp, bus.in_rmode, bus.in_tag));
        end
    end

    task automatic drive(input logic v, input logic sg, input logic [SW-1:0] m,
                         input logic [EXP_W-1:0] e, input logic [1:0] rm,
                         input logic [TAG_W-1:0] t);
        bus.in_valid = v;
        bus.in_sign  = sg;
        bus.in_mant  = m;
        bus.in_exp   = e;
        bus.in_rmode = rm;
        bus.in_tag   = t;
    endtask

    task automatic drive_random(input logic [TAG_W-1:0] t);
        logic [SW-1:0]    m;
        logic [EXP_W-1:0] e;
        m = SW'($urandom);
        if ($urandom_range(0, 1) == 1) m = m >> $urandom_range(0, SW - 1);
        if ($urandom_range(0, 15) == 0) m = '0;
        case ($urandom_range(0, 3))
            0:       e = EXP_W'($urandom);
            1:       e = EXP_W'($urandom_range(0, 12));
            2:       e = EXP_W'($urandom_range(248, 255));
            default: e = 8'h80;
        endcase
        drive(1'b1, 1'($urandom), m, e, 2'($urandom), t);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        int c0, n, sent, stale;
        vt.push_back('{1'b0, 12'hC00, 8'h80, 2'd0, 8'hC0, 8'h81, 4'b0000});
        vt.push_back('{1'b0, 12'h40C, 8'h80, 2'd0, 8'h82, 8'h80, 4'b0001});
        vt.push_back('{1'b0, 12'h40C, 8'h80, 2'd1, 8'h81, 8'h80, 4'b0001});
        vt.push_back('{1'b0, 12'h404, 8'h80, 2'd0, 8'h80, 8'h80, 4'b0001});
        vt.push_back('{1'b0, 12'h7FC, 8'h80, 2'd0, 8'h80, 8'h81, 4'b0001});
        vt.push_back('{1'b0, 12'h7FC, 8'h80, 2'd3, 8'hFF, 8'h80, 4'b0001});
        vt.push_back('{1'b0, 12'h010, 8'h80, 2'd0, 8'h80, 8'h7A, 4'b0000});
        vt.push_back('{1'b0, 12'h010, 8'h06, 2'd0, 8'h00, 8'h00, 4'b1011});
        vt.push_back('{1'b0, 12'h000, 8'h80, 2'd0, 8'h00, 8'h00, 4'b1000});
        vt.push_back('{1'b0, 12'hC00, 8'hFE, 2'd0, 8'h80, 8'hFF, 4'b0101});
        vt.push_back('{1'b1, 12'h7F9, 8'h80, 2'd3, 8'h80, 8'h81, 4'b0001});
        vt.push_back('{1'b0, 12'h7F9, 8'h80, 2'd2, 8'h80, 8'h81, 4'b0001});
        vt.push_back('{1'b1, 12'h7F9, 8'h80, 2'd2, 8'hFF, 8'h80, 4'b0001});
        vt.push_back('{1'b0, 12'hC01, 8'h80, 2'd0, 8'hC0, 8'h81, 4'b0001});

        drive(1'b0, 1'b0, '0, '0, 2'd0, '0);
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_in_ready", longint'(bus.in_ready), 0);
        chk("reset_out_valid", longint'(bus.out_valid), 0);
        chk("reset_outputs", longint'({bus.out_mant, bus.out_exp, bus.out_zero, bus.out_ovf,
                                       bus.out_uf, bus.out_inexact, bus.out_tag}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("in_ready_after_release", longint'(bus.in_ready), 1);

        // Directed vectors, one token at a time, latency measured per token.
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(1'b1, vt[i].sign, vt[i].m, vt[i].e, vt[i].rm, TAG_W'(i));
            #2;
            chk($sformatf("vec%0d_accept", i), longint'(bus.in_ready), 1);
            c0 = cyc;
            @(negedge clk);
            bus.in_valid = 1'b0;
            #2;
            n = 0;
            while (!bus.out_valid && n < 10) begin
                @(negedge clk);
                #2;
                n++;
            end
            chk($sformatf("vec%0d_latency", i), longint'(cyc - c0), 3);
            chk($sformatf("vec%0d_result", i),
                longint'({bus.out_mant, bus.out_exp, bus.out_zero, bus.out_ovf, bus.out_uf, bus.out_inexact}),
                longint'({vt[i].xm, vt[i].xe, vt[i].xf}));
        end
        repeat (4) @(negedge clk);

        // Backpressure: six tagged tokens, sink stalls for four cycles.
        tags_out.delete();
        sent = 0;
        for (int cy = 0; cy < 40 && tags_out.size() < 6; cy++) begin
            @(negedge clk);
            bus.out_ready = !(cy >= 3 && cy < 7);
            if (sent < 6) drive_random(TAG_W'(sent));
            else          bus.in_valid = 1'b0;
            #2;
            if (bus.out_valid && !bus.out_ready)
                chk("stall_in_ready", longint'(bus.in_ready), 0);
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        chk("bp_tag_count", longint'(tags_out.size()), 6);
        for (int i = 0; i < 6 && i < tags_out.size(); i++)
            chk($sformatf("bp_tag_order%0d", i), longint'(tags_out[i]), i);
        repeat (4) @(negedge clk);

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_random(TAG_W'(8 + i));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("midrst_in_ready", longint'(bus.in_ready), 0);
        @(negedge clk);
        #2;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_outputs", longint'({bus.out_mant, bus.out_exp, bus.out_zero, bus.out_ovf,
                                        bus.out_uf, bus.out_inexact}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #2;
        chk("midrst_ready_release", longint'(bus.in_ready), 1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #2;
            if (bus.out_valid) stale++;
        end
        chk("midrst_no_stale", stale, 0);

        // Randomized stream with random bubbles and backpressure.
        sent = 0;
        for (int cy = 0; cy < 4000 && (sent < 300 || sbq.size() != 0); cy++) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (sent < 300 && $urandom_range(0, 3) != 0) drive_random(TAG_W'(sent));
            else                                         bus.in_valid = 1'b0;
            #2;
            if (bus.in_valid && bus.in_ready) sent++;
        end
        chk("rand_sent", sent, 300);
        chk("rand_drained", longint'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
